// File: rtl/blinky_runner_if.sv
// Run-control and LED status bundle between a blinky_runner and whatever drives/observes it.
// The slave side is the blinker itself; the master side supplies the enable and watches the outputs.
interface blinky_runner_if #(
  parameter int COUNT_W = 16
);
  logic               en_i;
  logic               led_o;
  logic               on_pulse_o;
  logic               off_pulse_o;
  logic [COUNT_W-1:0] blink_count_o;

  modport master (
    output en_i,
    input  led_o,
    input  on_pulse_o,
    input  off_pulse_o,
    input  blink_count_o
  );

  modport slave (
    input  en_i,
    output led_o,
    output on_pulse_o,
    output off_pulse_o,
    output blink_count_o
  );
endinterface

// File: rtl/blinky_runner.sv
// Enable-gated LED blinker: OFF_CYCLES low, ON_CYCLES high, with one-cycle phase-entry pulses
// and a wrapping count of completed on-to-off transitions. Every output comes straight from a flop.
module blinky_runner #(
  parameter int ON_CYCLES  = 500_000,
  parameter int OFF_CYCLES = 500_000,
  parameter int COUNT_W    = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  blinky_runner_if.slave bus
);

  localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);

  generate
    if (ON_CYCLES < 1 || OFF_CYCLES < 1) begin : g_param_check
      $fatal(1, "blinky_runner: ON_CYCLES and OFF_CYCLES must both be >= 1");
    end
  endgenerate

  typedef enum logic {
    PH_OFF = 1'b0,
    PH_ON  = 1'b1
  } phase_t;

  phase_t             r_phase, w_phase_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_led, w_led_nxt;
  logic               r_on_pulse, w_on_pulse_nxt;
  logic               r_off_pulse, w_off_pulse_nxt;
  logic [COUNT_W-1:0] r_blink, w_blink_nxt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_phase     <= PH_OFF;
      r_cnt       <= '0;
      r_led       <= 1'b0;
      r_on_pulse  <= 1'b0;
      r_off_pulse <= 1'b0;
      r_blink     <= '0;
    end else begin
      r_phase     <= w_phase_nxt;
      r_cnt       <= w_cnt_nxt;
      r_led       <= w_led_nxt;
      r_on_pulse  <= w_on_pulse_nxt;
      r_off_pulse <= w_off_pulse_nxt;
      r_blink     <= w_blink_nxt;
    end
  end

  // Disabled edges hold everything but still clear the pulses, so a stall never stretches one.
  always_comb begin
    w_phase_nxt     = r_phase;
    w_cnt_nxt       = r_cnt;
    w_led_nxt       = r_led;
    w_on_pulse_nxt  = 1'b0;
    w_off_pulse_nxt = 1'b0;
    w_blink_nxt     = r_blink;
    if (bus.en_i) begin
      case (r_phase)
        PH_OFF: begin
          if (r_cnt == OFF_LAST) begin
            w_phase_nxt    = PH_ON;
            w_cnt_nxt      = '0;
            w_led_nxt      = 1'b1;
            w_on_pulse_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        PH_ON: begin
          if (r_cnt == ON_LAST) begin
            w_phase_nxt     = PH_OFF;
            w_cnt_nxt       = '0;
            w_led_nxt       = 1'b0;
            w_off_pulse_nxt = 1'b1;
            w_blink_nxt     = r_blink + 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.led_o         = r_led;
  assign bus.on_pulse_o    = r_on_pulse;
  assign bus.off_pulse_o   = r_off_pulse;
  assign bus.blink_count_o = r_blink;

endmodule

// File: tb/tb_blinky_runner.sv
// Directed bench for blinky_runner: a 4-on/6-off instance for timing, stall and async reset,
// plus a 1-on/1-off instance with a 2-bit blink counter for single-cycle phases and wrap.
module tb_blinky_runner;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   rise_cnt;
  int   fall_cnt;
  logic prev_led;

  blinky_runner_if #(.COUNT_W(16)) bus_a ();
  blinky_runner_if #(.COUNT_W(2))  bus_b ();

  blinky_runner #(
    .ON_CYCLES (4),
    .OFF_CYCLES(6),
    .COUNT_W   (16)
  ) u_dut_a (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus_a)
  );

  blinky_runner #(
    .ON_CYCLES (1),
    .OFF_CYCLES(1),
    .COUNT_W   (2)
  ) u_dut_b (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, sample 1 ns later, and confirm the pulses never coincide.
  task automatic step();
    @(posedge clk);
    #1;
    chk("excl_a", 32'(bus_a.on_pulse_o & bus_a.off_pulse_o), 32'd0);
    chk("excl_b", 32'(bus_b.on_pulse_o & bus_b.off_pulse_o), 32'd0);
  endtask

  task automatic chk_a(input string tag, input logic led, input logic onp, input logic offp,
                       input int cnt);
    chk({tag, "_a_led"}, 32'(bus_a.led_o), 32'(led));
    chk({tag, "_a_on"},  32'(bus_a.on_pulse_o), 32'(onp));
    chk({tag, "_a_off"}, 32'(bus_a.off_pulse_o), 32'(offp));
    chk({tag, "_a_cnt"}, 32'(bus_a.blink_count_o), 32'(cnt));
  endtask

  // Unstalled 4/6 waveform, e = rising edges since reset release: rise at 6, 16, 26 ...
  task automatic chk_a_free(input string tag, input int e);
    logic led, onp, offp;
    int   cnt;
    led  = (e >= 6) && (((e - 6) % 10) < 4);
    onp  = (e >= 6) && (((e - 6) % 10) == 0);
    offp = (e >= 10) && (((e - 6) % 10) == 4);
    cnt  = (e >= 10) ? ((e - 10) / 10 + 1) : 0;
    chk_a(tag, led, onp, offp, cnt);
  endtask

  // 1/1 waveform: led high on odd edges, falls on even edges, 2-bit count wraps.
  task automatic chk_b_free(input string tag, input int e);
    chk({tag, "_b_led"}, 32'(bus_b.led_o), 32'(e % 2));
    chk({tag, "_b_on"},  32'(bus_b.on_pulse_o), 32'(e % 2));
    chk({tag, "_b_off"}, 32'(bus_b.off_pulse_o), 32'((e % 2) == 0));
    chk({tag, "_b_cnt"}, 32'(bus_b.blink_count_o), 32'((e / 2) % 4));
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rise_cnt    = 0;
    fall_cnt    = 0;
    rst_n       = 1'b0;
    bus_a.en_i  = 1'b1;
    bus_b.en_i  = 1'b1;

    // Reset held across clock edges
    repeat (3) @(posedge clk);
    #1;
    chk_a("rst", 1'b0, 1'b0, 1'b0, 0);
    chk({"rst", "_b_led"}, 32'(bus_b.led_o), 32'd0);
    chk({"rst", "_b_cnt"}, 32'(bus_b.blink_count_o), 32'd0);

    // Free run: first rise at edge 6, four full periods over 40 edges
    rst_n    = 1'b1;
    prev_led = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      step();
      chk_a_free("run", e);
      if (bus_a.led_o && !prev_led) rise_cnt++;
      if (!bus_a.led_o && prev_led) fall_cnt++;
      prev_led = bus_a.led_o;
    end
    chk("rises40", 32'(rise_cnt), 32'd4);
    chk("falls40", 32'(fall_cnt), 32'd4);

    // Reach on-phase cycle 2 (rise at edge 46, second on cycle at edge 47)
    for (int e = 41; e <= 47; e++) begin
      step();
      chk_a_free("pre", e);
    end

    // Stall for 5 edges: everything frozen, no pulses
    bus_a.en_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_a("stall", 1'b1, 1'b0, 1'b0, 4);
    end
    bus_a.en_i = 1'b1;

    // Two remaining enabled on cycles, then the fall
    step();
    chk_a("resume1", 1'b1, 1'b0, 1'b0, 4);
    step();
    chk_a("resume2", 1'b1, 1'b0, 1'b0, 4);
    step();
    chk_a("fall", 1'b0, 1'b0, 1'b1, 5);

    // Full 6-cycle off phase, then rise
    for (int k = 1; k <= 5; k++) begin
      step();
      chk_a("off", 1'b0, 1'b0, 1'b0, 5);
    end
    step();
    chk_a("rise", 1'b1, 1'b1, 1'b0, 5);
    step();
    chk_a("on2", 1'b1, 1'b0, 1'b0, 5);

    // Asynchronous reset mid on-phase, between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk_a("arst", 1'b0, 1'b0, 1'b0, 0);
    step();
    chk_a("arst_hold", 1'b0, 1'b0, 1'b0, 0);

    // Release: both instances restart from a full off phase
    rst_n = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      chk_a_free("rel", e);
      chk_b_free("rel", e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/blinky_runner.md
BLINKY_RUNNER -- requirements
Module: blinky_runner

Interface
REQ-001 Parameter ON_CYCLES, default 500_000: number of clock cycles led_o is high per blink; SHALL be >= 1.
REQ-002 Parameter OFF_CYCLES, default 500_000: number of clock cycles led_o is low per blink; SHALL be >= 1.
REQ-003 Parameter COUNT_W, default 16: width of blink_count_o.
REQ-004 Ports SHALL be exactly the following.
- clk_i  input  1  sole clock; all state updates on rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- en_i  input  1  run enable; low freezes all state.
- led_o  output  1  registered LED drive, 1 = on.
- on_pulse_o  output  1  high for exactly the first cycle of each on-phase.
- off_pulse_o  output  1  high for exactly the first cycle of each off-phase that follows an on-phase.
- blink_count_o  output  COUNT_W  number of completed on-to-off transitions.
REQ-005 The block SHALL use one clock; reset SHALL be asynchronous and active-low.

Function
REQ-006 State: phase register (OFF, ON), cycle counter wide enough for max(ON_CYCLES, OFF_CYCLES)-1, blink counter, two pulse registers; all outputs SHALL be driven directly from flops.
REQ-007 In OFF with en_i=1, the counter SHALL increment each edge; on the edge where counter == OFF_CYCLES-1, phase SHALL become ON, counter SHALL clear to 0, led_o SHALL become 1 and on_pulse_o SHALL become 1.
REQ-008 In ON with en_i=1, the counter SHALL increment each edge; on the edge where counter == ON_CYCLES-1, phase SHALL become OFF, counter SHALL clear, led_o SHALL become 0, off_pulse_o SHALL become 1 and blink_count_o SHALL increment by 1.
REQ-009 on_pulse_o and off_pulse_o SHALL be 0 on every edge that does not perform the corresponding transition; they SHALL never be high together.
REQ-010 With en_i held 1 from reset release, led_o SHALL first rise after exactly OFF_CYCLES rising edges, stay high exactly ON_CYCLES cycles, then stay low exactly OFF_CYCLES cycles; period SHALL be ON_CYCLES+OFF_CYCLES.
REQ-011 ON_CYCLES=1 or OFF_CYCLES=1 SHALL yield a phase lasting exactly one cycle (counter compares against 0).
REQ-012 With en_i=0 on an edge, phase, counter, led_o and blink_count_o SHALL hold, and both pulse outputs SHALL be 0 on that edge; resuming en_i=1 SHALL continue the phase with the remaining cycle count, no cycles lost or added.
REQ-013 blink_count_o SHALL wrap from 2^COUNT_W-1 to 0 without affecting blinking.
REQ-014 led_o SHALL never glitch: it changes only on a rising clock edge or on reset assertion.
REQ-015 Parameter violation (ON_CYCLES<1 or OFF_CYCLES<1) SHALL be reported by an elaboration-time assertion.

Reset
REQ-016 While rst_ni=0, regardless of clock: phase=OFF, counter=0, led_o=0, on_pulse_o=0, off_pulse_o=0, blink_count_o=0.
REQ-017 Reset assertion SHALL take effect immediately (asynchronously), including mid on-phase; reset deassertion SHALL be consumed synchronously, first counting edge being the first rising edge after rst_ni goes high.
REQ-018 After reset release the block SHALL restart from the beginning of an OFF phase (full OFF_CYCLES before first on).

Verification
REQ-019 ON_CYCLES=4, OFF_CYCLES=6, en_i=1, release reset -> led_o rises on edge 6, falls on edge 10, rises on edge 16; on_pulse_o high cycles 6 and 16, off_pulse_o high cycle 10.
REQ-020 Same params, run 4 full on/off cycles (40 edges) -> exactly 4 rising and 4 falling led_o edges, blink_count_o = 4, every high width 4 and low width 6.
REQ-021 Same params, drop en_i for 5 cycles at on-phase cycle 2 -> led_o held 1 during stall, on-phase total still 4 enabled cycles, no pulses during stall.
REQ-022 Assert rst_ni=0 mid on-phase between clock edges -> led_o and blink_count_o go 0 immediately; after release led_o rises again after 6 edges.
REQ-023 COUNT_W=2, ON_CYCLES=1, OFF_CYCLES=1 -> led_o toggles every cycle; blink_count_o sequence 1,2,3,0,1 after successive falls.
REQ-024 Throughout all scenarios -> on_pulse_o and off_pulse_o never simultaneously high, each exactly one cycle wide.
